// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input, program-memory write port and load status of prog_loader.
interface prog_loader_if;
  logic start;
  logic rx_valid;
  logic [7:0] rx_data;
  logic rx_ready;
  logic mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_din;
  logic busy;
  logic done;
  logic err;
  logic [1:0] err_code;
  modport master (
    output start, rx_valid, rx_data,
    input rx_ready, mem_we, mem_addr, mem_din, busy, done, err, err_code
  );
  modport slave (
    input start, rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_din, busy, done, err, err_code
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: loads a length-prefixed, checksummed little-endian word image from a byte stream into program memory.
module prog_loader #(
  parameter logic [13:0] BASE_ADDR = 14'h0000,
  parameter int MAX_WORDS = 4096,
  parameter int TIMEOUT_CYC = 100000
) (
  input logic clk,
  input logic rst_n,
  prog_loader_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0] MAXW = 17'(MAX_WORDS);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CKSUM, DONE, ERR} state_t;
  state_t r_state, w_next;
  logic [1:0] r_code, w_code;
  logic [7:0] r_len_lo, r_sum;
  logic [15:0] r_len, r_wcnt, w_n;
  logic [1:0] r_bcnt;
  logic [23:0] r_asm;
  logic [TW-1:0] r_tmo;
  logic r_we;
  logic [13:0] r_addr;
  logic [31:0] r_din;
  logic w_busy, w_acc, w_tmo, w_start, w_word, w_last;
  assign w_busy = r_state inside {LEN_LO, LEN_HI, DATA, CKSUM};
  assign w_acc = bus.rx_valid && w_busy;
  assign w_start = bus.start && !w_busy;
  assign w_tmo = w_busy && !w_acc && r_tmo == TLAST;
  assign w_n = {bus.rx_data, r_len_lo};
  assign w_word = r_state == DATA && w_acc && r_bcnt == 2'd3;
  assign w_last = w_word && r_wcnt == r_len - 16'd1;
  assign bus.rx_ready = w_busy;
  assign bus.busy = w_busy;
  assign bus.done = r_state == DONE;
  assign bus.err = r_state == ERR;
  assign bus.err_code = r_code;
  assign bus.mem_we = r_we;
  assign bus.mem_addr = r_addr;
  assign bus.mem_din = r_din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_code <= 2'b00;
    end else begin
      r_state <= w_next;
      r_code <= w_code;
    end
  always_comb begin
    w_next = r_state;
    w_code = r_code;
    if (w_start) begin
      w_next = LEN_LO;
      w_code = 2'b00;
    end else if (w_tmo) begin
      w_next = ERR;
      w_code = 2'b11;
    end else if (w_acc) begin
      case (r_state)
        LEN_LO: w_next = LEN_HI;
        LEN_HI: begin
          w_next = {1'b0, w_n} > MAXW ? ERR : (w_n == 16'd0 ? CKSUM : DATA);
          w_code = {1'b0, w_n} > MAXW ? 2'b01 : r_code;
        end
        DATA: w_next = w_last ? CKSUM : DATA;
        CKSUM: begin
          w_next = bus.rx_data == r_sum ? DONE : ERR;
          w_code = bus.rx_data == r_sum ? r_code : 2'b10;
        end
        default: w_next = r_state;
      endcase
    end
  end
  // The write port is registered from the fourth byte; r_asm only ever holds bytes 0..2.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_we <= 1'b0;
      r_addr <= BASE_ADDR;
      r_din <= '0;
      r_len_lo <= '0;
      r_len <= '0;
      r_wcnt <= '0;
      r_bcnt <= '0;
      r_sum <= '0;
      r_asm <= '0;
      r_tmo <= '0;
    end else begin
      r_we <= w_word;
      r_tmo <= (w_start || w_acc || !w_busy) ? '0 : r_tmo + 1'b1;
      if (w_word) begin
        r_addr <= BASE_ADDR + {r_wcnt[11:0], 2'b00};
        r_din <= {bus.rx_data, r_asm};
      end
      if (w_start) begin
        r_len_lo <= '0;
        r_len <= '0;
        r_wcnt <= '0;
        r_bcnt <= '0;
        r_sum <= '0;
      end else if (w_acc) begin
        case (r_state)
          LEN_LO: r_len_lo <= bus.rx_data;
          LEN_HI: r_len <= w_n;
          DATA: begin
            r_sum <= r_sum + bus.rx_data;
            r_bcnt <= r_bcnt + 2'd1;
            if (w_word) r_wcnt <= r_wcnt + 16'd1;
            case (r_bcnt)
              2'd0: r_asm[7:0] <= bus.rx_data;
              2'd1: r_asm[15:8] <= bus.rx_data;
              2'd2: r_asm[23:16] <= bus.rx_data;
              default: r_asm <= r_asm;
            endcase
          end
          default: r_sum <= r_sum;
        endcase
      end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench for prog_loader; expected writes are queued as bytes are driven.
module tb_prog_loader;
  localparam int T = 20;
  logic clk = 0;
  logic rst_n = 0;
  int n_chk = 0;
  int n_pass = 0;
  logic we_due = 0;
  logic [7:0] sum;
  logic [45:0] sb[$];
  logic [45:0] e;
  prog_loader_if bus();
  prog_loader #(.BASE_ADDR(14'h0000), .MAX_WORDS(4096), .TIMEOUT_CYC(T)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  always @(negedge clk) begin
    if (bus.mem_we || we_due) chk("we_timing", {63'd0, bus.mem_we}, {63'd0, we_due});
    if (bus.mem_we) begin
      if (sb.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        e = sb.pop_front();
        chk("mem_addr", bus.mem_addr, e[45:32]);
        chk("mem_din", bus.mem_din, e[31:0]);
      end
    end
    we_due = 0;
  end
  task automatic send_byte(input logic [7:0] b, input logic wd);
    @(negedge clk);
    bus.rx_valid = 1;
    bus.rx_data = b;
    chk("rx_ready", bus.rx_ready, 1);
    @(posedge clk);
    we_due = wd;
  endtask
  task automatic send_pay(input logic [7:0] b, input logic wd);
    sum = sum + b;
    send_byte(b, wd);
  endtask
  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[7:0], 0);
    send_byte(n[15:8], 0);
  endtask
  task automatic send_word(input int k, input logic [31:0] w);
    sb.push_back({14'(4 * k), w});
    for (int i = 0; i < 4; i++) send_pay(w[8*i +: 8], i == 3);
  endtask
  task automatic gap(input int c);
    @(negedge clk);
    bus.rx_valid = 0;
    repeat (c) @(posedge clk);
  endtask
  task automatic do_start();
    @(negedge clk);
    bus.rx_valid = 0;
    bus.start = 1;
    @(posedge clk);
    #1 bus.start = 0;
    sum = 0;
  endtask
  task automatic end_status(input string tag, input logic d, input logic er, input logic [1:0] c);
    @(negedge clk);
    bus.rx_valid = 0;
    chk({tag, "_done"}, bus.done, d);
    chk({tag, "_err"}, bus.err, er);
    chk({tag, "_code"}, bus.err_code, c);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_pending"}, sb.size(), 0);
  endtask
  task automatic reset_vals(input string tag);
    chk({tag, "_rdy"}, bus.rx_ready, 0);
    chk({tag, "_we"}, bus.mem_we, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_addr"}, bus.mem_addr, 14'h0000);
    chk({tag, "_din"}, bus.mem_din, 0);
    chk({tag, "_code"}, bus.err_code, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end
  initial begin
    bus.start = 0;
    bus.rx_valid = 0;
    bus.rx_data = 0;
    sum = 0;
    repeat (2) @(negedge clk);
    reset_vals("rst");
    rst_n = 1;
    repeat (2) @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    do_start();
    send_hdr(16'd1);
    send_word(0, 32'h000010B7);
    chk("t1_sum", sum, 8'hC7);
    send_byte(sum, 0);
    end_status("t1", 1, 0, 2'b00);
    repeat (3) @(negedge clk);
    chk("t1_hold", bus.done, 1);
    do_start();
    send_hdr(16'd2);
    send_word(0, 32'h00808093);
    send_word(1, 32'h000FF137);
    send_byte(sum, 0);
    end_status("t2", 1, 0, 2'b00);
    chk("t2_addr_hold", bus.mem_addr, 14'h0004);
    chk("t2_din_hold", bus.mem_din, 32'h000FF137);
    do_start();
    send_hdr(16'h1001);
    end_status("t3", 0, 1, 2'b01);
    do_start();
    send_hdr(16'd1);
    send_word(0, 32'hDEADBEEF);
    send_byte(sum ^ 8'h5A, 0);
    end_status("t4", 0, 1, 2'b10);
    do_start();
    chk("t4_restart_err", bus.err, 0);
    send_hdr(16'd1);
    send_word(0, 32'h12345678);
    send_byte(sum, 0);
    end_status("t4b", 1, 0, 2'b00);
    do_start();
    send_hdr(16'd1);
    send_pay(8'h11, 0);
    send_pay(8'h22, 0);
    gap(T);
    end_status("t5", 0, 1, 2'b11);
    do_start();
    send_hdr(16'd1);
    sb.push_back({14'h0000, 32'h44332211});
    send_pay(8'h11, 0);
    send_pay(8'h22, 0);
    gap(T - 1);
    send_pay(8'h33, 0);
    send_pay(8'h44, 1);
    send_byte(sum, 0);
    end_status("t5b", 1, 0, 2'b00);
    do_start();
    send_hdr(16'd0);
    send_byte(8'h00, 0);
    end_status("t6", 1, 0, 2'b00);
    do_start();
    send_hdr(16'd1);
    send_word(0, 32'hCAFE0001);
    send_byte(sum, 0);
    end_status("t6b", 1, 0, 2'b00);
    do_start();
    send_hdr(16'd1);
    sb.push_back({14'h0000, 32'hA5C3B2E1});
    send_pay(8'hE1, 0);
    send_pay(8'hB2, 0);
    @(negedge clk);
    bus.rx_valid = 0;
    bus.start = 1;
    @(posedge clk);
    #1 bus.start = 0;
    chk("t7_busy", bus.busy, 1);
    send_pay(8'hC3, 0);
    send_pay(8'hA5, 1);
    send_byte(sum, 0);
    end_status("t7", 1, 0, 2'b00);
    do_start();
    send_hdr(16'd2);
    send_word(0, 32'h0BADF00D);
    send_pay(8'h77, 0);
    @(negedge clk);
    bus.rx_valid = 0;
    #2 rst_n = 0;
    #1 reset_vals("t8");
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("t8_idle_busy", bus.busy, 0);
    chk("t8_idle_we", bus.mem_we, 0);
    end_status("t8", 0, 0, 2'b00);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
